// File: rtl/subtractor64_unit_pkg.sv
// Shared constants for the registered Y86-64 subtractor.
package subtractor64_unit_pkg;
    localparam int SUB_WIDTH = 64;
    localparam int SUB_MSB   = SUB_WIDTH - 1;

    function automatic int msb_of(input int w);
        return w - 1;
    endfunction
endpackage

// File: rtl/subtractor64_unit_full_subtractor_1bit.sv
// One bit of the ripple-borrow chain: difference bit and borrow-out.
module full_subtractor_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/subtractor64_unit.sv
// Registered a - b with signed overflow and unsigned borrow, 1-cycle latency.
module subtractor64_unit
    import subtractor64_unit_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] difference,
    output logic             overflow,
    output logic             borrow
);
    localparam int MSB = (WIDTH == SUB_WIDTH) ? SUB_MSB : msb_of(WIDTH);

    logic [WIDTH:0]   bchain;
    logic [WIDTH-1:0] diff_c;
    logic             ovf_c;

    assign bchain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_subtractor_1bit u_fs (
            .x    (a[i]),
            .y    (b[i]),
            .bin  (bchain[i]),
            .d    (diff_c[i]),
            .bout (bchain[i+1])
        );
    end

    // Signed overflow: operands of differing sign and result sign flipped away from a.
    assign ovf_c = (a[MSB] != b[MSB]) && (diff_c[MSB] != a[MSB]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            difference <= '0;
            overflow   <= 1'b0;
            borrow     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                difference <= diff_c;
                overflow   <= ovf_c;
                borrow     <= bchain[WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_subtractor64_unit.sv
// Self-checking bench for subtractor64_unit: directed table, sweep, random stream, reset.
module tb_subtractor64_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a, b;
    logic        out_valid;
    logic [63:0] difference;
    logic        overflow, borrow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    subtractor64_unit #(.WIDTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .difference (difference),
        .overflow   (overflow),
        .borrow     (borrow)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] d;
        logic        of;
        logic        bo;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Reference: exact integer subtraction in 65 bits, then range/compare rules.
    function automatic vec_t model(input logic [63:0] x, input logic [63:0] y);
        vec_t r;
        logic signed [64:0] sfull;
        sfull = $signed({x[63], x}) - $signed({y[63], y});
        r.a  = x;
        r.b  = y;
        r.d  = x - y;
        r.of = (sfull > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (sfull < -65'sh0_8000_0000_0000_0000);
        r.bo = (x < y);
        return r;
    endfunction

    task automatic check_out(input string nm, input logic v, input vec_t e);
        chk({nm, ".valid"}, {63'd0, out_valid}, {63'd0, v});
        chk({nm, ".diff"},  difference,         e.d);
        chk({nm, ".of"},    {63'd0, overflow},  {63'd0, e.of});
        chk({nm, ".bo"},    {63'd0, borrow},    {63'd0, e.bo});
    endtask

    task automatic apply(input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    vec_t tbl[5];
    vec_t e, last;
    vec_t zero_v;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        zero_v = '{a: 64'd0, b: 64'd0, d: 64'd0, of: 1'b0, bo: 1'b0};

        // Outputs must be zero during reset, before any clock edge matters.
        #3;
        check_out("reset", 1'b0, zero_v);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b0};
        tbl[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE1, 64'h8000_0000_0000_001E, 1'b1, 1'b1};
        tbl[2] = '{64'h65E0_007F_F0D5_5500, 64'h7F00_0000_0000_0055, 64'hE6E0_007F_F0D5_54AB, 1'b0, 1'b1};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        tbl[4] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = tbl[i].a; b = tbl[i].b; in_valid = 1'b1;
            @(negedge clk);
            check_out($sformatf("tbl%0d", i), 1'b1, tbl[i]);
            in_valid = 1'b0;
        end

        // 5x5 sweep near all-ones, back to back.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                a = 64'hFFFF_FFFF_FFFF_FFFE - 64'(i);
                b = 64'hFFFF_FFFF_FFFF_FFFF - 64'(j);
                in_valid = 1'b1;
                e = model(a, b);
                @(negedge clk);
                check_out($sformatf("sweep%0d_%0d", i, j), 1'b1, e);
            end
        end
        in_valid = 1'b0;

        // Random back-to-back stream with random valid gaps; invalid cycles hold results.
        @(negedge clk);
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_valid = 1'b1;
        last = model(a, b);
        for (int k = 0; k < 300; k++) begin
            logic v;
            logic [63:0] ra, rb;
            v = in_valid;
            @(negedge clk);
            check_out($sformatf("rand%0d", k), v, last);
            case ($urandom_range(0, 3))
                0: begin ra = {$urandom, $urandom}; rb = ra; end
                1: begin ra = {1'b1, 63'd0} ^ 64'($urandom_range(0, 3)); rb = 64'($urandom_range(0, 3)); end
                default: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
            endcase
            a = ra; b = rb;
            in_valid = ($urandom_range(0, 4) != 0);
            if (in_valid) last = model(a, b);
        end
        @(negedge clk);
        check_out("rand_last", in_valid, last);
        in_valid = 1'b0;

        // Hold: one valid result, then an invalid cycle with different operands.
        @(negedge clk);
        a = 64'd100; b = 64'd7; in_valid = 1'b1;
        e = model(a, b);
        @(negedge clk);
        check_out("hold_pre", 1'b1, e);
        a = 64'd5; b = 64'd9; in_valid = 1'b0;
        @(negedge clk);
        check_out("hold", 1'b0, e);

        // Asynchronous reset asserted between edges while a result is pending.
        a = 64'd1; b = 64'd2; in_valid = 1'b1;
        @(posedge clk);
        a = 64'd50; b = 64'd3;
        #2 rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, zero_v);
        @(negedge clk);
        check_out("rst_held", 1'b0, zero_v);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_out("post_rst_idle", 1'b0, zero_v);
        apply(64'd50, 64'd3);
        check_out("post_rst", 1'b1, model(64'd50, 64'd3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/subtractor64_unit.md
Name: subtractor64_unit

Overview:
- Registered 64-bit two's-complement subtractor for the Y86-64 ALU datapath.
- Computes difference = a - b, plus a signed overflow flag and an unsigned borrow flag.
- Results are captured in output registers one clock after the operands are presented.
- Feeds the ALU result mux and the condition-code logic (OF from overflow, CF-style information from borrow).

Parameters:
- WIDTH, 64, operand and result width. Only 64 is required to be supported; the logic is written generically.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on a/b are valid this cycle.
- a  input  WIDTH  minuend (signed two's complement).
- b  input  WIDTH  subtrahend (signed two's complement).
- out_valid  output  1  registered; result fields are valid.
- difference  output  WIDTH  registered a - b, modulo 2^WIDTH.
- overflow  output  1  registered signed-overflow flag.
- borrow  output  1  registered unsigned-borrow flag.

Behaviour:
- Reset: while rst_n = 0, out_valid, difference, overflow and borrow are all 0. Reset takes effect immediately, without waiting for clk. The first capture happens on the first rising edge after rst_n returns to 1.
- Arithmetic (combinational, before the registers): difference = a + ~b + 1, built as a ripple-borrow chain of 1-bit full subtractors. Bit 0 has borrow-in 0.
- borrow = final borrow-out of bit WIDTH-1. This equals 1 exactly when a < b as unsigned numbers.
- overflow = (a[MSB] != b[MSB]) && (difference[MSB] != a[MSB]).
- Latency: exactly 1 cycle. On a rising edge with in_valid = 1, the register captures difference, overflow and borrow for that a/b, and out_valid becomes 1.
- With in_valid = 0 at a rising edge: out_valid becomes 0 and the result registers hold their previous values.
- Back-to-back operation: a new operand pair is accepted every cycle. There is no backpressure.
- Wrap-around: the result is always modulo 2^64. Examples: 0 - 1 = all ones with borrow = 1; MIN - 1 = MAX with overflow = 1.
- a == b gives difference 0, overflow 0, borrow 0. This includes a = b = all ones.
- Reset asserted mid-stream: any pending result is discarded, and outputs read 0 immediately.
- No X propagation: with known inputs, all outputs are known.

Decomposition:
- Shared package: WIDTH default constant (64), and MSB index helper constant WIDTH-1.
- One natural sub-module: full_subtractor_1bit.
  - Inputs: x, y, bin. Outputs: d, bout.
  - d = x ^ y ^ bin.
  - bout = (~x & y) | (~(x ^ y) & bin).
- The top level instantiates WIDTH copies in a generate loop, then adds the flag logic and the output register stage.

Test Plan:
- Equal operands: a = b = 0xFFFF_FFFF_FFFF_FFFF, in_valid = 1. Next cycle: difference = 0, overflow = 0, borrow = 0, out_valid = 1.
- Sweep: a from 0xFFFF_FFFF_FFFF_FFFE down by 1, b from 0xFFFF_FFFF_FFFF_FFFF down by 1, 5x5 grid. Each result matches a model a - b. Example: a = 0xFFFF_FFFF_FFFF_FFFE, b = 0xFFFF_FFFF_FFFF_FFFF gives difference = 0xFFFF_FFFF_FFFF_FFFF, borrow = 1, overflow = 0.
- Positive overflow: a = 0x7FFF_FFFF_FFFF_FFFF, b = 0xFFFF_FFFF_FFFF_FFE1 (-31). Result: difference = 0x8000_0000_0000_001E, overflow = 1, borrow = 1.
- Large positives, no signed overflow: a = 0x65E0_007F_F0D5_5500, b = 0x7F00_0000_0000_0055. Result: difference = 0xE6E0_007F_F0D5_54AB, overflow = 0, borrow = 1.
- Negative overflow: a = 0x8000_0000_0000_0000, b = 1. Result: difference = 0x7FFF_FFFF_FFFF_FFFF, overflow = 1, borrow = 0.
- Reset and valid: drive rst_n low asynchronously between edges mid-stream. All outputs go to 0 immediately. With in_valid = 0 for one cycle, out_valid = 0 and difference holds its last value.
